// File: rtl/march_bist_engine.sv
// march_bist_engine
//   March C- self-test sequencer for a synchronous single-port SRAM with
//   per-lane write enables. Runs M0..M5 over addresses 0..DEPTH-1 for each
//   lane in turn, compares reads against the selected background, streams
//   one error record per failing read and reports pass/fail at the end.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, bg_sel       run request; background (0 solid, 1 checkerboard)
//   busy, done, pass    run status (pass valid while done)
//   mem_addr/we/re      SRAM address, one-hot lane write enable, read strobe
//   mem_wdata/rdata     lane word replicated on write; full-width read data
//   err_valid/addr/lane/elem/syn/bit/multi   per-failure record
//   err_cnt             saturating failure count
module march_bist_engine #(
  parameter int ADDR_W    = 17,
  parameter int DEPTH     = 131072,
  parameter int LANE_W    = 8,
  parameter int LANES     = 2,
  parameter int ERR_CNT_W = 8,
  localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BIT_W      = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    bg_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES-1:0]        mem_we,
  output logic                    mem_re,
  output logic [LANES*LANE_W-1:0] mem_wdata,
  input  logic [LANES*LANE_W-1:0] mem_rdata,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [LANE_IDX_W-1:0]   err_lane,
  output logic [2:0]              err_elem,
  output logic [LANE_W-1:0]       err_syn,
  output logic [BIT_W-1:0]        err_bit,
  output logic                    err_multi,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0]     LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  // sequencer state: counters describe the next operation to issue
  logic [1:0]            state_q, state_d;
  logic                  drain_q, drain_d;
  logic                  bg_q, bg_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  ph_q, ph_d;

  // issue stage (drives the SRAM) and its read context
  logic [LANES-1:0]      we_q;
  logic                  re_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LANE_W-1:0]     wdata_q;
  logic [LANE_IDX_W-1:0] rd_lane_q;
  logic [2:0]            rd_elem_q;
  logic [LANE_W-1:0]     rd_exp_q;

  // compare stage: aligned with mem_rdata
  logic                  pend_v_q;
  logic [ADDR_W-1:0]     pend_addr_q;
  logic [LANE_IDX_W-1:0] pend_lane_q;
  logic [2:0]            pend_elem_q;
  logic [LANE_W-1:0]     pend_exp_q;

  // result registers
  logic                  err_valid_q;
  logic [ADDR_W-1:0]     err_addr_q;
  logic [LANE_IDX_W-1:0] err_lane_q;
  logic [2:0]            err_elem_q;
  logic [LANE_W-1:0]     err_syn_q;
  logic [BIT_W-1:0]      err_bit_q;
  logic                  err_multi_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic                  err_seen_q;
  logic                  done_q;
  logic                  pass_q;

  // combinational
  logic                  starting, issue, two_op, is_read, bit_val, last_op;
  logic [LANE_IDX_W-1:0] c_lane;
  logic [2:0]            c_elem;
  logic [ADDR_W-1:0]     c_idx, c_addr;
  logic                  c_ph, c_bg;
  logic [LANE_W-1:0]     c_data;
  logic [LANES-1:0]      we_mask;
  logic [LANE_W-1:0]     rd_slice, syn;
  logic                  mismatch, found, multi;
  logic [BIT_W-1:0]      low_bit;

  // The first operation is issued on the same edge that accepts start, so
  // the current-op view is forced to lane 0 / M0 / index 0 while starting.
  always_comb begin
    starting = start && (state_q == S_IDLE || state_q == S_DONE);
    issue    = starting || (state_q == S_RUN);
    c_lane   = starting ? '0 : lane_q;
    c_elem   = starting ? '0 : elem_q;
    c_idx    = starting ? '0 : idx_q;
    c_ph     = starting ? 1'b0 : ph_q;
    c_bg     = starting ? bg_sel : bg_q;

    two_op  = (c_elem >= 3'd1) && (c_elem <= 3'd4);
    is_read = (c_elem == 3'd5) || (two_op && !c_ph);
    c_addr  = (c_elem == 3'd3 || c_elem == 3'd4) ? (LAST_IDX - c_idx) : c_idx;
    bit_val = is_read ? (c_elem == 3'd2 || c_elem == 3'd4)
                      : (c_elem == 3'd1 || c_elem == 3'd3);
    c_data  = {LANE_W{bit_val ^ (c_bg & c_addr[0])}};

    we_mask = '0;
    for (int unsigned l = 0; l < LANES; l++)
      we_mask[l] = (c_lane == LANE_IDX_W'(l));

    lane_d  = lane_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    last_op = 1'b0;
    if (issue) begin
      lane_d = c_lane;
      elem_d = c_elem;
      idx_d  = c_idx;
      ph_d   = 1'b0;
      if (two_op && !c_ph) begin
        ph_d = 1'b1;
      end else if (c_idx != LAST_IDX) begin
        idx_d = c_idx + 1'b1;
      end else begin
        idx_d = '0;
        if (c_elem != 3'd5) begin
          elem_d = c_elem + 3'd1;
        end else begin
          elem_d = '0;
          if (c_lane == LAST_LANE) last_op = 1'b1;
          else                     lane_d  = c_lane + 1'b1;
        end
      end
    end

    state_d = state_q;
    drain_d = drain_q;
    bg_d    = bg_q;
    if (starting) begin
      state_d = S_RUN;
      bg_d    = bg_sel;
    end else begin
      case (state_q)
        S_RUN: if (last_op) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
        S_DRAIN: begin
          drain_d = 1'b1;
          if (drain_q) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // compare against the lane the read was issued for
  always_comb begin
    rd_slice = '0;
    for (int unsigned l = 0; l < LANES; l++)
      if (pend_lane_q == LANE_IDX_W'(l)) rd_slice = mem_rdata[l*LANE_W +: LANE_W];
    syn      = rd_slice ^ pend_exp_q;
    mismatch = pend_v_q && (syn != '0);
    multi    = (syn & (syn - 1'b1)) != '0;
    low_bit  = '0;
    found    = 1'b0;
    for (int unsigned b = 0; b < LANE_W; b++) begin
      if (syn[b] && !found) begin
        low_bit = BIT_W'(b);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_q     <= 1'b0;
      bg_q        <= 1'b0;
      lane_q      <= '0;
      elem_q      <= '0;
      idx_q       <= '0;
      ph_q        <= 1'b0;
      we_q        <= '0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_lane_q   <= '0;
      rd_elem_q   <= '0;
      rd_exp_q    <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_lane_q <= '0;
      pend_elem_q <= '0;
      pend_exp_q  <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_lane_q  <= '0;
      err_elem_q  <= '0;
      err_syn_q   <= '0;
      err_bit_q   <= '0;
      err_multi_q <= 1'b0;
      err_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      bg_q    <= bg_d;
      lane_q  <= lane_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;

      we_q <= (issue && !is_read) ? we_mask : '0;
      re_q <= issue && is_read;
      if (issue) begin
        addr_q    <= c_addr;
        rd_lane_q <= c_lane;
        rd_elem_q <= c_elem;
        rd_exp_q  <= c_data;
        if (!is_read) wdata_q <= c_data;
      end

      pend_v_q    <= re_q;
      pend_addr_q <= addr_q;
      pend_lane_q <= rd_lane_q;
      pend_elem_q <= rd_elem_q;
      pend_exp_q  <= rd_exp_q;

      err_valid_q <= mismatch;
      if (mismatch) begin
        err_addr_q  <= pend_addr_q;
        err_lane_q  <= pend_lane_q;
        err_elem_q  <= pend_elem_q;
        err_syn_q   <= syn;
        err_bit_q   <= low_bit;
        err_multi_q <= multi;
      end

      if (starting) begin
        err_cnt_q  <= '0;
        err_seen_q <= 1'b0;
        done_q     <= 1'b0;
        pass_q     <= 1'b0;
      end else begin
        if (mismatch) begin
          err_seen_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
        // the final read's compare lands on the same edge that ends DRAIN
        if (state_q == S_DRAIN && drain_q) begin
          done_q <= 1'b1;
          pass_q <= !(err_seen_q || mismatch);
        end
      end
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = done_q;
  assign pass      = pass_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_wdata = {LANES{wdata_q}};
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_lane  = err_lane_q;
  assign err_elem  = err_elem_q;
  assign err_syn   = err_syn_q;
  assign err_bit   = err_bit_q;
  assign err_multi = err_multi_q;
  assign err_cnt   = err_cnt_q;

endmodule
